// File: rtl/sramlike_bus_arbiter_pkg.sv
// sramlike_bus_arbiter_pkg: shared state, grant and size encodings for the sram-like arbiter
package sramlike_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_ADDR = 3'd1,
        ST_D_ADDR = 3'd2,
        ST_I_DATA = 3'd3,
        ST_D_DATA = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/sramlike_rr_pick.sv
// sramlike_rr_pick: picks inst or data master by fixed data priority or round-robin
module sramlike_rr_pick
    import sramlike_bus_arbiter_pkg::*;
#(
    parameter int DATA_PRIO = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic inst_req,
    input  logic data_req,
    input  logic upd,
    input  logic upd_data,
    output gnt_t pick
);

    logic last_data;

    // remember who won the last address handshake; reset favours inst on the first tie
    always_ff @(posedge clk) begin
        if (rst)
            last_data <= 1'b1;
        else if (upd)
            last_data <= upd_data;
    end

    // same-cycle pick among the current requesters
    always_comb begin
        pick = GNT_NONE;
        if (DATA_PRIO != 0)
            pick = data_req ? GNT_D : inst_req ? GNT_I : GNT_NONE;
        else
            pick = (inst_req && data_req) ? (last_data ? GNT_I : GNT_D) :
                   data_req ? GNT_D : inst_req ? GNT_I : GNT_NONE;
    end

endmodule

// File: rtl/sramlike_bus_arbiter.sv
// sramlike_bus_arbiter: shares one sram-like slave between inst and data masters, one outstanding transaction
module sramlike_bus_arbiter
    import sramlike_bus_arbiter_pkg::*;
#(
    parameter int DATA_PRIO = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok
);

    state_t state, state_nx;
    gnt_t   pick, owner;
    logic   addr_phase, req_i, req_d, hs;

    sramlike_rr_pick #(.DATA_PRIO(DATA_PRIO)) u_pick (
        .clk      (clk),
        .rst      (rst),
        .inst_req (inst_req),
        .data_req (data_req),
        .upd      (hs),
        .upd_data (req_d),
        .pick     (pick)
    );

    // owner is the fresh pick in IDLE, otherwise locked to the master holding the transaction
    always_comb begin
        owner      = (state == ST_IDLE) ? pick :
                     (state == ST_I_ADDR || state == ST_I_DATA) ? GNT_I : GNT_D;
        addr_phase = state == ST_IDLE || state == ST_I_ADDR || state == ST_D_ADDR;
        req_i      = addr_phase && owner == GNT_I && inst_req;
        req_d      = addr_phase && owner == GNT_D && data_req;
        hs         = (req_i || req_d) && bus_addr_ok;
    end

    // route the granted master onto the slave and the slave handshakes back to the owner only
    always_comb begin
        bus_req      = req_i || req_d;
        bus_wr       = req_i ? inst_wr    : req_d ? data_wr    : 1'b0;
        bus_size     = req_i ? inst_size  : req_d ? data_size  : 2'b00;
        bus_addr     = req_i ? inst_addr  : req_d ? data_addr  : '0;
        bus_wdata    = req_i ? inst_wdata : req_d ? data_wdata : '0;
        inst_addr_ok = req_i && bus_addr_ok;
        data_addr_ok = req_d && bus_addr_ok;
        inst_data_ok = bus_data_ok && ((req_i && bus_addr_ok) || state == ST_I_DATA);
        data_data_ok = bus_data_ok && ((req_d && bus_addr_ok) || state == ST_D_DATA);
        inst_rdata   = bus_rdata;
        data_rdata   = bus_rdata;
    end

    // next state: stray data_ok outside a data phase without a same-cycle handshake is ignored
    always_comb begin
        state_nx = state;
        case (state)
            ST_I_DATA, ST_D_DATA: state_nx = bus_data_ok ? ST_IDLE : state;
            default: begin
                if (!(req_i || req_d))
                    state_nx = ST_IDLE;
                else if (bus_addr_ok)
                    state_nx = bus_data_ok ? ST_IDLE : req_i ? ST_I_DATA : ST_D_DATA;
                else
                    state_nx = req_i ? ST_I_ADDR : ST_D_ADDR;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

endmodule
